svi_count_array: RTL and testbench
==================================

Name: svi_count_array

Overview:
Parametrised multi-channel start/stop counter array. It is the next generation of the single 8-bit start-triggered counter behind the my_svi master modport, generalised to NUM_CH channels, WIDTH bits and a programmable terminal count. Each channel adds wrap/hold mode, completed-run tracking (count2), sticky error reporting and a done pulse. It sits beside the control logic that drives start/enable and consumes error/count2.

Parameters:
WIDTH, 8, bit width of count, count2 and limit per channel (>=2)
NUM_CH, 4, number of independent channels (>=1)
WRAP_DEFAULT, 0, reset value of the per-channel wrap mode bit

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous, active-low reset
start  input  NUM_CH  per-channel start request, sampled each cycle
enable  input  NUM_CH  per-channel count enable (the modport's enable, per channel)
clear  input  NUM_CH  per-channel synchronous clear
wrap_mode  input  NUM_CH  1 = wrap at terminal count, 0 = hold; latched at start
limit  input  NUM_CH*WIDTH  terminal count per channel (channel i at [i*WIDTH +: WIDTH]); latched at start
count  output  NUM_CH*WIDTH  current count per channel
count2  output  NUM_CH*WIDTH  completed-run counter per channel, saturating
busy  output  NUM_CH  channel in RUN
done  output  NUM_CH  one-cycle pulse per terminal-count hit
error  output  NUM_CH  sticky protocol error

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on reset_n.
- Reset values:
  - state IDLE; count = 0; count2 = 0; busy = 0; done = 0; error = 0.
  - Latched limit = 0; latched wrap = WRAP_DEFAULT.
- Channels are fully independent. All outputs are registered.
- Per-channel FSM: IDLE, RUN, HOLD, ERR.
- Priority per edge: clear > start > count.
- clear (any state): next state IDLE; count = 0; count2 = 0; error = 0; done = 0. A start in the same cycle is ignored.
- IDLE or HOLD + start:
  - Latch limit and wrap_mode; count = 0; next state RUN; busy = 1 after that edge.
  - No error.
- RUN + start: error = 1 (sticky); next state ERR; count frozen; done not pulsed.
- RUN + enable, count != limit_q: count += 1.
- RUN + enable, count == limit_q:
  - done = 1 for exactly one cycle.
  - count2 += 1, saturating at all-ones.
  - If wrap latched: count = 0 and stay in RUN.
  - Otherwise: count holds limit_q, next state HOLD, busy = 0.
- RUN + !enable: hold everything.
- limit_q = 0: the first enabled cycle in RUN hits terminal count. In wrap mode done pulses every enabled cycle.
- ERR: start and enable are ignored; only clear or reset exits.
- Changing limit or wrap_mode mid-run has no effect until the next start.
- Timing example, limit = 3, enable held high, start sampled at edge E0:
  - count = 0, 1, 2, 3 after E0..E3.
  - done = 1 after E4, together with the count2 increment.
  - Hold mode: count stays 3 and busy drops after E4.
  - Wrap mode: count = 0 after E4.
- reset_n assertion mid-run: all outputs reach reset values immediately (asynchronous), with no clock required. Deassertion must be synchronised externally.
- count and count2 are unsigned WIDTH bits. No arithmetic carries out of WIDTH except the defined wrap and saturation.

Decomposition:
- Package svi_count_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, HOLD, ERR} svi_cnt_state_e
  - default WIDTH/NUM_CH constants
  - a packed channel-status struct {busy, done, error}
- Sub-module svi_count_chan implements one channel: FSM, count, count2, latched limit/wrap.
- svi_count_array instantiates svi_count_chan NUM_CH times in a generate loop and slices the flat vectors.

Test Plan:
- WIDTH=8, ch0, limit=3, hold, enable=1, start pulse → count 0,1,2,3; done pulse 4 cycles after start; count2=1; busy=0; count holds 3.
- Wrap mode, limit=2, enable=1 for 9 cycles after start → count 0,1,2,0,1,2,0,…; done pulses every 3rd cycle; count2=3; busy stays 1.
- Start again while ch1 is in RUN → error[1]=1, count frozen; later starts ignored; clear → error=0, count=0, count2=0, IDLE. Other channels are unaffected.
- limit=0 with wrap → done=1 every enabled cycle; count2 saturates at 255 after 255 hits and stays there.
- Enable toggled 1,0,1,0 with limit=5 → count advances only on enabled edges; limit changed to 1 mid-run → terminal count still 5.
- reset_n asserted mid-run with count=7 → all outputs zero immediately, before the next clk edge. Simultaneous clear+start → IDLE, busy=0.

Source files
------------

// File: rtl/svi_count_pkg.sv
// Shared types and defaults for the multi-channel start/stop counter array.
// The array and its per-channel counter both import this package.
package svi_count_pkg;

  localparam int DEFAULT_WIDTH  = 8;
  localparam int DEFAULT_NUM_CH = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD,
    ERR
  } svi_cnt_state_e;

  typedef struct packed {
    logic busy;
    logic done;
    logic error;
  } svi_cnt_status_t;

endpackage

// File: rtl/svi_count_chan.sv
// One counter channel: IDLE/RUN/HOLD/ERR FSM, terminal-count detection,
// a saturating completed-run counter, and the limit/wrap latched at start.
module svi_count_chan
  import svi_count_pkg::*;
#(
  parameter int WIDTH        = DEFAULT_WIDTH,
  parameter bit WRAP_DEFAULT = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             enable,
  input  logic             clear,
  input  logic             wrap_mode,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count2,
  output svi_cnt_status_t  status
);

  svi_cnt_state_e   state;
  logic [WIDTH-1:0] limit_q;
  logic             wrap_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      count   <= '0;
      count2  <= '0;
      limit_q <= '0;
      wrap_q  <= WRAP_DEFAULT;
      status  <= '0;
    end else begin
      status.done <= 1'b0;
      if (clear) begin
        // clear wins over a start in the same cycle
        state        <= IDLE;
        count        <= '0;
        count2       <= '0;
        status.busy  <= 1'b0;
        status.error <= 1'b0;
      end else begin
        case (state)
          IDLE, HOLD: begin
            if (start) begin
              limit_q     <= limit;
              wrap_q      <= wrap_mode;
              count       <= '0;
              state       <= RUN;
              status.busy <= 1'b1;
            end
          end
          RUN: begin
            if (start) begin
              state        <= ERR;
              status.busy  <= 1'b0;
              status.error <= 1'b1;
            end else if (enable) begin
              if (count == limit_q) begin
                status.done <= 1'b1;
                if (count2 != '1) count2 <= count2 + 1'b1;
                if (wrap_q) begin
                  count <= '0;
                end else begin
                  state       <= HOLD;
                  status.busy <= 1'b0;
                end
              end else begin
                count <= count + 1'b1;
              end
            end
          end
          ERR: begin
            // sticky until clear or reset
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/svi_count_array.sv
// NUM_CH independent start/stop counters; flat per-channel vectors are
// sliced WIDTH bits per channel, channel i at [i*WIDTH +: WIDTH].
module svi_count_array
  import svi_count_pkg::*;
#(
  parameter int WIDTH        = DEFAULT_WIDTH,
  parameter int NUM_CH       = DEFAULT_NUM_CH,
  parameter bit WRAP_DEFAULT = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_CH-1:0]       start,
  input  logic [NUM_CH-1:0]       enable,
  input  logic [NUM_CH-1:0]       clear,
  input  logic [NUM_CH-1:0]       wrap_mode,
  input  logic [NUM_CH*WIDTH-1:0] limit,
  output logic [NUM_CH*WIDTH-1:0] count,
  output logic [NUM_CH*WIDTH-1:0] count2,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH-1:0]       done,
  output logic [NUM_CH-1:0]       error
);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    svi_cnt_status_t status;

    svi_count_chan #(
      .WIDTH       (WIDTH),
      .WRAP_DEFAULT(WRAP_DEFAULT)
    ) u_chan (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (start[gi]),
      .enable   (enable[gi]),
      .clear    (clear[gi]),
      .wrap_mode(wrap_mode[gi]),
      .limit    (limit[gi*WIDTH +: WIDTH]),
      .count    (count[gi*WIDTH +: WIDTH]),
      .count2   (count2[gi*WIDTH +: WIDTH]),
      .status   (status)
    );

    assign busy[gi]  = status.busy;
    assign done[gi]  = status.done;
    assign error[gi] = status.error;
  end

endmodule

// File: tb/tb_svi_count_array.sv
// Bench for svi_count_array: a behavioural channel model pushes expected
// outputs per edge into a scoreboard, popped and compared after the edge.
module tb_svi_count_array;

  localparam int W = 8;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [N-1:0]   start, enable, clear, wrap_mode;
  logic [N*W-1:0] limit;
  logic [N*W-1:0] count, count2;
  logic [N-1:0]   busy, done, error;

  always #5 clk = ~clk;

  svi_count_array #(
    .WIDTH       (W),
    .NUM_CH      (N),
    .WRAP_DEFAULT(1'b0)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .enable   (enable),
    .clear    (clear),
    .wrap_mode(wrap_mode),
    .limit    (limit),
    .count    (count),
    .count2   (count2),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  typedef struct {
    int           ch;
    logic [W-1:0] cnt;
    logic [W-1:0] c2;
    logic         b;
    logic         d;
    logic         e;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   ntick  = 0;

  // model state: 0 idle, 1 run, 2 hold, 3 err
  int           m_st  [N];
  logic [W-1:0] m_cnt [N];
  logic [W-1:0] m_c2  [N];
  logic [W-1:0] m_lim [N];
  logic         m_wrap[N];
  logic         m_done[N];
  logic         m_err [N];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      m_st[c] = 0; m_cnt[c] = '0; m_c2[c] = '0; m_lim[c] = '0;
      m_wrap[c] = 1'b0; m_done[c] = 1'b0; m_err[c] = 1'b0;
    end
  endtask

  // Advance the model by one edge using the inputs currently driven.
  task automatic model_step();
    exp_t e;
    for (int c = 0; c < N; c++) begin
      m_done[c] = 1'b0;
      if (clear[c]) begin
        m_st[c] = 0; m_cnt[c] = '0; m_c2[c] = '0; m_err[c] = 1'b0;
      end else if ((m_st[c] == 0 || m_st[c] == 2) && start[c]) begin
        m_lim[c] = limit[c*W +: W]; m_wrap[c] = wrap_mode[c];
        m_cnt[c] = '0; m_st[c] = 1;
      end else if (m_st[c] == 1 && start[c]) begin
        m_err[c] = 1'b1; m_st[c] = 3;
      end else if (m_st[c] == 1 && enable[c]) begin
        if (m_cnt[c] == m_lim[c]) begin
          m_done[c] = 1'b1;
          if (m_c2[c] != 8'hFF) m_c2[c] = m_c2[c] + 8'd1;
          if (m_wrap[c]) m_cnt[c] = '0;
          else m_st[c] = 2;
        end else begin
          m_cnt[c] = m_cnt[c] + 8'd1;
        end
      end
      e.ch = c; e.cnt = m_cnt[c]; e.c2 = m_c2[c];
      e.b = (m_st[c] == 1); e.d = m_done[c]; e.e = m_err[c];
      sb.push_back(e);
    end
  endtask

  task automatic tick();
    exp_t e;
    model_step();
    @(posedge clk);
    #1;
    ntick++;
    for (int c = 0; c < N; c++) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty ch%0d got=none expected=entry", c);
      end else begin
        e = sb.pop_front();
        check_val($sformatf("ch%0d_count", e.ch), 32'(count[e.ch*W +: W]), 32'(e.cnt));
        check_val($sformatf("ch%0d_count2", e.ch), 32'(count2[e.ch*W +: W]), 32'(e.c2));
        check_val($sformatf("ch%0d_busy", e.ch), 32'(busy[e.ch]), 32'(e.b));
        check_val($sformatf("ch%0d_done", e.ch), 32'(done[e.ch]), 32'(e.d));
        check_val($sformatf("ch%0d_error", e.ch), 32'(error[e.ch]), 32'(e.e));
      end
    end
    $display("tick %0d busy=%b done=%b error=%b count=%h count2=%h",
             ntick, busy, done, error, count, count2);
  endtask

  task automatic set_lim(input int c, input int v);
    limit[c*W +: W] = v[W-1:0];
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_count"}, count, 0);
    check_val({tag, "_count2"}, count2, 0);
    check_val({tag, "_busy"}, 32'(busy), 0);
    check_val({tag, "_done"}, 32'(done), 0);
    check_val({tag, "_error"}, 32'(error), 0);
  endtask

  initial begin
    reset_n = 1'b0; start = '0; enable = '0; clear = '0; wrap_mode = '0; limit = '0;
    model_reset();
    #1;
    check_all_zero("reset");
    @(posedge clk); #1;
    reset_n = 1'b1;

    // ch0: limit 3, hold mode
    set_lim(0, 3); wrap_mode[0] = 1'b0; enable[0] = 1'b1; start[0] = 1'b1;
    tick(); start[0] = 1'b0;
    check_val("hold_count_e0", 32'(count[7:0]), 0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      check_val("hold_done", 32'(done[0]), (k == 4) ? 1 : 0);
    end
    check_val("hold_count", 32'(count[7:0]), 3);
    check_val("hold_busy", 32'(busy[0]), 0);
    check_val("hold_count2", 32'(count2[7:0]), 1);

    // ch2: limit 2, wrap mode
    set_lim(2, 2); wrap_mode[2] = 1'b1; enable[2] = 1'b1; start[2] = 1'b1;
    tick(); start[2] = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      check_val("wrap_count", 32'(count[23:16]), k % 3);
      check_val("wrap_done", 32'(done[2]), (k % 3 == 0) ? 1 : 0);
    end
    check_val("wrap_count2", 32'(count2[23:16]), 3);
    check_val("wrap_busy", 32'(busy[2]), 1);
    enable[2] = 1'b0;

    // ch1: restart while running -> sticky error, then clear
    set_lim(1, 50); enable[1] = 1'b1; start[1] = 1'b1;
    tick(); start[1] = 1'b0;
    tick(); tick();
    start[1] = 1'b1; tick(); start[1] = 1'b0;
    check_val("err_flag", 32'(error[1]), 1);
    check_val("err_count", 32'(count[15:8]), 2);
    tick(); tick();
    check_val("err_frozen", 32'(count[15:8]), 2);
    start[1] = 1'b1; tick(); start[1] = 1'b0;
    check_val("err_sticky", 32'(error[1]), 1);
    clear[1] = 1'b1; tick(); clear[1] = 1'b0;
    check_val("clr_error", 32'(error[1]), 0);
    check_val("clr_count", 32'(count[15:8]), 0);
    check_val("clr_count2", 32'(count2[15:8]), 0);
    check_val("clr_busy", 32'(busy[1]), 0);
    enable[1] = 1'b0;

    // ch3: limit 0 with wrap -> done every enabled cycle, count2 saturates
    set_lim(3, 0); wrap_mode[3] = 1'b1; enable[3] = 1'b1; start[3] = 1'b1;
    tick(); start[3] = 1'b0;
    for (int k = 1; k <= 260; k++) begin
      tick();
      check_val("lim0_done", 32'(done[3]), 1);
    end
    check_val("lim0_sat", 32'(count2[31:24]), 255);
    enable[3] = 1'b0;

    // ch0: toggling enable, limit 5, limit changed mid-run
    set_lim(0, 5); wrap_mode[0] = 1'b0; enable[0] = 1'b0; start[0] = 1'b1;
    tick(); start[0] = 1'b0;
    set_lim(0, 1);
    for (int k = 1; k <= 12; k++) begin
      enable[0] = k[0];
      tick();
      check_val("tog_count", 32'(count[7:0]), ((k + 1) / 2 > 5) ? 5 : (k + 1) / 2);
      check_val("tog_done", 32'(done[0]), (k == 11) ? 1 : 0);
    end

    // ch0: asynchronous reset mid-run at count 7
    set_lim(0, 20); enable[0] = 1'b1; start[0] = 1'b1;
    tick(); start[0] = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    check_val("pre_rst_count", 32'(count[7:0]), 7);
    #2 reset_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    model_reset();
    @(posedge clk); #1;
    reset_n = 1'b1;

    // simultaneous clear + start -> stays IDLE
    set_lim(0, 3); clear[0] = 1'b1; start[0] = 1'b1;
    tick(); clear[0] = 1'b0; start[0] = 1'b0;
    check_val("clrstart_busy", 32'(busy[0]), 0);
    tick();
    check_val("clrstart_idle", 32'(count[7:0]), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
